// File: rtl/regfile_op_pkg.sv
// rtl/regfile_op_pkg.sv - shared opcodes, state encodings and widths for the op sequencer
package regfile_op_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD  = 3'b000;
  localparam op_t OP_SUB  = 3'b001;
  localparam op_t OP_AND  = 3'b010;
  localparam op_t OP_OR   = 3'b011;
  localparam op_t OP_XOR  = 3'b100;
  localparam op_t OP_MOV  = 3'b101;
  localparam op_t OP_LDI  = 3'b110;
  localparam op_t OP_RSVD = 3'b111;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/regfile_op_alu.sv
// rtl/regfile_op_alu.sv - combinational ALU: op/a/b/imm to result and carry/borrow
module regfile_op_alu
  import regfile_op_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // The extra top bit of the widened difference is the unsigned borrow (a < b).
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MOV:  result = a;
      OP_LDI:  result = imm;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/regfile_op_sequencer.sv
// rtl/regfile_op_sequencer.sv - reads operands, runs the ALU and writes back one command at a time
module regfile_op_sequencer
  import regfile_op_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rf_read_enable1,
  output logic              rf_read_enable2,
  output logic [ADDR_W-1:0] rf_read_address1,
  output logic [ADDR_W-1:0] rf_read_address2,
  input  logic [DATA_W-1:0] rf_read_out1,
  input  logic [DATA_W-1:0] rf_read_out2,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_write_address,
  output logic [DATA_W-1:0] rf_write_in,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              err
);

  logic [2:0]        state;
  op_t               op_q;
  logic [ADDR_W-1:0] rs1_q, rs2_q, rd_q;
  logic [DATA_W-1:0] imm_q, opa_q, opb_q;
  logic              carry_q;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              in_read;
  logic              rsvd;

  assign in_read = (state == ST_READ);
  assign rsvd    = (op_q == OP_RSVD);

  // Strobes decode straight from state so an asynchronous reset clears them at once.
  assign cmd_ready        = (state == ST_IDLE);
  assign rf_read_enable1  = in_read && (op_q != OP_LDI) && !rsvd;
  assign rf_read_enable2  = in_read && (op_q <= OP_XOR);
  assign rf_read_address1 = in_read ? rs1_q : '0;
  assign rf_read_address2 = in_read ? rs2_q : '0;
  assign rf_write_enable  = (state == ST_WRITE) && !rsvd;
  assign done             = (state == ST_DONE);

  regfile_op_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .a      (opa_q),
    .b      (opb_q),
    .imm    (imm_q),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      op_q             <= OP_ADD;
      rs1_q            <= '0;
      rs2_q            <= '0;
      rd_q             <= '0;
      imm_q            <= '0;
      opa_q            <= '0;
      opb_q            <= '0;
      carry_q          <= 1'b0;
      rf_write_address <= '0;
      rf_write_in      <= '0;
      result           <= '0;
      carry            <= 1'b0;
      zero             <= 1'b0;
      err              <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            rs1_q <= cmd_rs1;
            rs2_q <= cmd_rs2;
            rd_q  <= cmd_rd;
            imm_q <= cmd_imm;
            state <= ST_READ;
          end
        end
        ST_READ: begin
          opa_q <= rf_read_out1;
          opb_q <= rf_read_out2;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          rf_write_in      <= alu_result;
          rf_write_address <= rd_q;
          carry_q          <= alu_carry;
          state            <= ST_WRITE;
        end
        ST_WRITE: begin
          // Status lands on the edge into DONE so it is valid alongside the done pulse.
          result <= rf_write_in;
          carry  <= carry_q;
          zero   <= (rf_write_in == '0);
          err    <= rsvd;
          state  <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// tb/tb_regfile_op_sequencer.sv - scoreboard bench for regfile_op_sequencer with a 32x8 register file model
module tb_regfile_op_sequencer;
  import regfile_op_pkg::*;

  typedef struct packed {
    logic [2:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [7:0] imm;
  } cmd_t;

  typedef struct {
    bit         wr;
    logic [4:0] addr;
    logic [7:0] data;
    logic       carry;
    logic       zero;
    logic       err;
    bit         rd1;
    bit         rd2;
    logic [4:0] ra1;
    logic [4:0] ra2;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [4:0] cmd_rs1 = '0, cmd_rs2 = '0, cmd_rd = '0;
  logic [7:0] cmd_imm = '0;
  logic       rf_read_enable1, rf_read_enable2, rf_write_enable;
  logic [4:0] rf_read_address1, rf_read_address2, rf_write_address;
  logic [7:0] rf_read_out1 = '0, rf_read_out2 = '0, rf_write_in;
  logic       done, carry, zero, err;
  logic [7:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_op_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_rs1          (cmd_rs1),
    .cmd_rs2          (cmd_rs2),
    .cmd_rd           (cmd_rd),
    .cmd_imm          (cmd_imm),
    .rf_read_enable1  (rf_read_enable1),
    .rf_read_enable2  (rf_read_enable2),
    .rf_read_address1 (rf_read_address1),
    .rf_read_address2 (rf_read_address2),
    .rf_read_out1     (rf_read_out1),
    .rf_read_out2     (rf_read_out2),
    .rf_write_enable  (rf_write_enable),
    .rf_write_address (rf_write_address),
    .rf_write_in      (rf_write_in),
    .done             (done),
    .result           (result),
    .carry            (carry),
    .zero             (zero),
    .err              (err)
  );

  // 32x8 register file: reads sample on the falling edge, writes on the rising edge.
  logic [7:0] rf_mem [32];
  logic [7:0] rf_model [32];
  initial for (int i = 0; i < 32; i++) begin rf_mem[i] = 8'h00; rf_model[i] = 8'h00; end

  always @(negedge clk) begin
    if (rf_read_enable1) rf_read_out1 <= rf_mem[rf_read_address1];
    if (rf_read_enable2) rf_read_out2 <= rf_mem[rf_read_address2];
  end
  always @(posedge clk) if (rf_write_enable) rf_mem[rf_write_address] <= rf_write_in;

  int         wr_total = 0, rd1_total = 0, rd2_total = 0;
  logic [4:0] last_wa, last_ra1, last_ra2;
  logic [7:0] last_wd;
  always @(negedge clk) begin
    if (rf_write_enable) begin wr_total++; last_wa = rf_write_address; last_wd = rf_write_in; end
    if (rf_read_enable1) begin rd1_total++; last_ra1 = rf_read_address1; end
    if (rf_read_enable2) begin rd2_total++; last_ra2 = rf_read_address2; end
  end

  exp_t sb[$];

  int         o_lat, o_wait, o_wr, o_rd1, o_rd2;
  bit         o_ready_bad;
  logic [4:0] o_wa, o_ra1, o_ra2;
  logic [7:0] o_wd, o_res;
  logic       o_c, o_z, o_e;

  task automatic send(input cmd_t c, input bit keep_valid);
    exp_t e;
    logic [7:0] a, b, r;
    logic       cy;
    int w0, r10, r20;
    bit acc;
    a = rf_model[c.rs1];
    b = rf_model[c.rs2];
    cy = 1'b0;
    case (c.op)
      OP_ADD:  {cy, r} = {1'b0, a} + {1'b0, b};
      OP_SUB:  begin r = a - b; cy = (a < b); end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_MOV:  r = a;
      OP_LDI:  r = c.imm;
      default: r = 8'h00;
    endcase
    e.wr = (c.op != OP_RSVD);
    e.addr = c.rd; e.data = r; e.carry = cy; e.zero = (r == 8'h00); e.err = (c.op == OP_RSVD);
    e.rd1 = (c.op <= OP_MOV); e.rd2 = (c.op <= OP_XOR); e.ra1 = c.rs1; e.ra2 = c.rs2;
    if (e.wr) rf_model[c.rd] = r;
    sb.push_back(e);

    @(negedge clk);
    cmd_valid = 1'b1;
    {cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_imm} = c;
    acc = 1'b0;
    o_wait = -1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin acc = 1'b1; o_wait = i; break; end
      @(negedge clk);
    end
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: cmd_ready got 0 want 1 within 20 cycles");
    end
    w0 = wr_total; r10 = rd1_total; r20 = rd2_total;
    @(posedge clk); #1;
    if (!keep_valid) cmd_valid = 1'b0;
    o_lat = -1;
    o_ready_bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cmd_ready && k < 4) o_ready_bad = 1'b1;
      if (done) begin
        o_lat = k; o_res = result; o_c = carry; o_z = zero; o_e = err;
        break;
      end
    end
    o_wr = wr_total - w0; o_wa = last_wa; o_wd = last_wd;
    o_rd1 = rd1_total - r10; o_rd2 = rd2_total - r20; o_ra1 = last_ra1; o_ra2 = last_ra2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    n_cmp++;
    if ({rf_read_enable1, rf_read_enable2, rf_write_enable, done, carry, zero, err, result,
         rf_write_in, rf_write_address, rf_read_address1, rf_read_address2} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got en=%b%b%b done=%b flags=%b%b%b res=%h wd=%h wa=%h ra=%h/%h want all 0",
               rf_read_enable1, rf_read_enable2, rf_write_enable, done, carry, zero, err, result,
               rf_write_in, rf_write_address, rf_read_address1, rf_read_address2);
    end
    rst = 1'b0;
  endtask

  task automatic test_ops();
    cmd_t t[11];
    exp_t e;
    t = '{'{OP_LDI, 5'd0, 5'd0, 5'd3, 8'h25}, '{OP_LDI, 5'd0, 5'd0, 5'd4, 8'h0F},
          '{OP_ADD, 5'd3, 5'd4, 5'd5, 8'h77}, '{OP_LDI, 5'd0, 5'd0, 5'd1, 8'hFF},
          '{OP_LDI, 5'd0, 5'd0, 5'd2, 8'h01}, '{OP_ADD, 5'd1, 5'd2, 5'd6, 8'h00},
          '{OP_SUB, 5'd4, 5'd3, 5'd7, 8'h00}, '{OP_AND, 5'd3, 5'd4, 5'd12, 8'h00},
          '{OP_OR,  5'd3, 5'd4, 5'd13, 8'h00}, '{OP_XOR, 5'd3, 5'd4, 5'd14, 8'h00},
          '{OP_MOV, 5'd3, 5'd4, 5'd15, 8'hAA}};
    for (int i = 0; i < 11; i++) begin
      send(t[i], 1'b0);
      e = sb.pop_front();
      n_cmp++;
      if (o_lat !== 3) begin n_bad++; $display("FAIL ops%0d_latency: got %0d want 3", i, o_lat); end
      n_cmp++;
      if (o_ready_bad !== 1'b0) begin n_bad++; $display("FAIL ops%0d_ready_busy: got high want low", i); end
      n_cmp++;
      if (o_wr !== 1 || o_wa !== e.addr || o_wd !== e.data) begin
        n_bad++;
        $display("FAIL ops%0d_write: got n=%0d a=%0d d=%h want n=1 a=%0d d=%h", i, o_wr, o_wa, o_wd, e.addr, e.data);
      end
      n_cmp++;
      if (o_rd1 !== int'(e.rd1) || o_rd2 !== int'(e.rd2)) begin
        n_bad++;
        $display("FAIL ops%0d_read_en: got %0d/%0d want %0d/%0d", i, o_rd1, o_rd2, e.rd1, e.rd2);
      end
      if (e.rd2) begin
        n_cmp++;
        if (o_ra1 !== e.ra1 || o_ra2 !== e.ra2) begin
          n_bad++;
          $display("FAIL ops%0d_read_addr: got %0d/%0d want %0d/%0d", i, o_ra1, o_ra2, e.ra1, e.ra2);
        end
      end
      n_cmp++;
      if ({o_res, o_c, o_z, o_e} !== {e.data, e.carry, e.zero, e.err}) begin
        n_bad++;
        $display("FAIL ops%0d_status: got res=%h c=%b z=%b e=%b want res=%h c=%b z=%b e=%b",
                 i, o_res, o_c, o_z, o_e, e.data, e.carry, e.zero, e.err);
      end
    end
  endtask

  task automatic test_reserved();
    exp_t e;
    send('{OP_RSVD, 5'd1, 5'd2, 5'd9, 8'h55}, 1'b0);
    e = sb.pop_front();
    n_cmp++;
    if (o_wr !== 0 || o_rd1 !== 0 || o_rd2 !== 0) begin
      n_bad++;
      $display("FAIL rsvd_no_access: got wr=%0d rd=%0d/%0d want 0/0/0", o_wr, o_rd1, o_rd2);
    end
    n_cmp++;
    if (o_lat !== 3 || {o_res, o_c, o_z, o_e} !== {e.data, e.carry, e.zero, e.err}) begin
      n_bad++;
      $display("FAIL rsvd_status: got lat=%0d res=%h c=%b z=%b e=%b want lat=3 res=%h c=%b z=%b e=%b",
               o_lat, o_res, o_c, o_z, o_e, e.data, e.carry, e.zero, e.err);
    end
    send('{OP_MOV, 5'd9, 5'd0, 5'd10, 8'h00}, 1'b0);
    e = sb.pop_front();
    n_cmp++;
    if (o_wr !== 1 || o_wa !== e.addr || o_wd !== e.data || {o_res, o_z, o_e} !== {e.data, e.zero, e.err}) begin
      n_bad++;
      $display("FAIL mov_after_rsvd: got a=%0d d=%h res=%h z=%b e=%b want a=%0d d=%h res=%h z=%b e=%b",
               o_wa, o_wd, o_res, o_z, o_e, e.addr, e.data, e.data, e.zero, e.err);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    send('{OP_ADD, 5'd3, 5'd3, 5'd3, 8'h00}, 1'b1);
    e = sb.pop_front();
    n_cmp++;
    if (o_ready_bad !== 1'b0 || o_lat !== 3 || o_wd !== e.data || o_wa !== e.addr) begin
      n_bad++;
      $display("FAIL b2b_first: got busy_ready=%b lat=%0d a=%0d d=%h want 0 3 %0d %h",
               o_ready_bad, o_lat, o_wa, o_wd, e.addr, e.data);
    end
    send('{OP_SUB, 5'd3, 5'd4, 5'd16, 8'h00}, 1'b0);
    e = sb.pop_front();
    n_cmp++;
    if (o_wait !== 0) begin n_bad++; $display("FAIL b2b_accept_edge: got wait=%0d want 0", o_wait); end
    n_cmp++;
    if (o_ready_bad !== 1'b0 || o_wd !== e.data || o_c !== e.carry || o_res !== e.data) begin
      n_bad++;
      $display("FAIL b2b_second: got busy_ready=%b d=%h res=%h c=%b want 0 %h %h %b",
               o_ready_bad, o_wd, o_res, o_c, e.data, e.data, e.carry);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [7:0] keep;
    keep = rf_model[8];
    @(negedge clk);
    cmd_valid = 1'b1;
    {cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_imm} = {OP_ADD, 5'd3, 5'd4, 5'd8, 8'h00};
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_cmp++;
    if (rf_read_enable1 !== 1'b1) begin n_bad++; $display("FAIL mid_in_read: rd_en1 got %b want 1", rf_read_enable1); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || {rf_read_enable1, rf_read_enable2, rf_write_enable, done} !== 4'b0 ||
        {result, carry, zero, err} !== '0 || {rf_read_address1, rf_read_address2} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got ready=%b en=%b%b%b done=%b res=%h flags=%b%b%b want ready=1 rest 0",
               cmd_ready, rf_read_enable1, rf_read_enable2, rf_write_enable, done, result, carry, zero, err);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (rf_mem[8] !== keep) begin n_bad++; $display("FAIL mid_reset_target: r8 got %h want %h", rf_mem[8], keep); end
    send('{OP_MOV, 5'd3, 5'd0, 5'd11, 8'h00}, 1'b0);
    e = sb.pop_front();
    n_cmp++;
    if (o_lat !== 3 || o_wa !== e.addr || o_wd !== e.data || o_res !== e.data) begin
      n_bad++;
      $display("FAIL mid_reset_next: got lat=%0d a=%0d d=%h res=%h want 3 %0d %h %h",
               o_lat, o_wa, o_wd, o_res, e.addr, e.data, e.data);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_reserved();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
